pll_reset_ctrl: RTL

Sequences the 12->30 MHz PLL primitive and releases the system reset only after lock has been stable for a programmable time. Runs on the 12 MHz reference clock, which is independent of the PLL. Drives the PLL RESETB pin and retries PLL reset on lock timeout. Detects lock loss and re-asserts system reset. Sits at top level between the board clock pin, the PLL and the per-domain reset synchronizers.

---
 rtl/pll_reset_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl: brings up the 12->30 MHz PLL and releases the system reset
// only after the PLL has reported lock continuously for STABLE_CYCLES cycles.
// Runs entirely on the 12 MHz reference clock, which is independent of the PLL.
//
// Ports:
//   clock           12 MHz reference clock (same net as the PLL input)
//   reset_n         asynchronous active-low reset
//   locked          PLL LOCK, asynchronous to clock
//   restart         one-cycle synchronous request to restart the sequence
//   pll_resetb      PLL RESETB (0 = PLL held in reset)
//   sys_reset_n     active-low system reset, resynchronized by each consumer
//   ready           1 while the PLL clock is usable (RUN)
//   fail            1 after MAX_RETRIES consecutive lock timeouts (sticky)
//   retry_count     lock timeouts since the last successful lock, saturating
//   lock_loss_count lock losses seen while running, saturating
module pll_reset_ctrl #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT   = 65536,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       locked,
  input  logic       restart,
  output logic       pll_resetb,
  output logic       sys_reset_n,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_count,
  output logic [7:0] lock_loss_count
);

  localparam int unsigned RST_W = $clog2(PLL_RST_CYCLES + 1);
  localparam int unsigned STB_W = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned TO_W  = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RUN       = 2'd2,
    ST_FAIL      = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     locked_s;
  logic [RST_W-1:0]         rst_cnt_q, rst_cnt_d;
  logic [TO_W-1:0]          timeout_cnt_q, timeout_cnt_d;
  logic [STB_W-1:0]         stable_cnt_q, stable_cnt_d;
  logic [3:0]               retry_q, retry_d, retry_inc;
  logic [7:0]               llc_q, llc_d;
  logic                     pll_resetb_q, pll_resetb_d;
  logic                     sys_reset_n_q, sys_reset_n_d;
  logic                     ready_q, ready_d;
  logic                     fail_q, fail_d;

  // Lock synchronizer; only the last stage feeds any decision.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
    end
  end

  assign locked_s  = sync_q[SYNC_STAGES-1];
  assign retry_inc = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;

  // State, counters and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_PLL_RST;
      rst_cnt_q     <= '0;
      timeout_cnt_q <= '0;
      stable_cnt_q  <= '0;
      retry_q       <= '0;
      llc_q         <= '0;
      pll_resetb_q  <= 1'b0;
      sys_reset_n_q <= 1'b0;
      ready_q       <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      stable_cnt_q  <= stable_cnt_d;
      retry_q       <= retry_d;
      llc_q         <= llc_d;
      pll_resetb_q  <= pll_resetb_d;
      sys_reset_n_q <= sys_reset_n_d;
      ready_q       <= ready_d;
      fail_q        <= fail_d;
    end
  end

  // Next-state and counter logic; restart overrides every state.
  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    stable_cnt_d  = stable_cnt_q;
    retry_d       = retry_q;
    llc_d         = llc_q;

    if (restart) begin
      state_d       = ST_PLL_RST;
      rst_cnt_d     = '0;
      timeout_cnt_d = '0;
      stable_cnt_d  = '0;
      retry_d       = '0;
    end else begin
      unique case (state_q)
        ST_PLL_RST: begin
          if (rst_cnt_q == RST_W'(PLL_RST_CYCLES - 1)) begin
            state_d       = ST_WAIT_LOCK;
            rst_cnt_d     = '0;
            timeout_cnt_d = '0;
            stable_cnt_d  = '0;
          end else begin
            rst_cnt_d = rst_cnt_q + RST_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          timeout_cnt_d = timeout_cnt_q + TO_W'(1);
          stable_cnt_d  = locked_s ? stable_cnt_q + STB_W'(1) : '0;
          // Stable completion is checked first so it wins a tie with timeout.
          if (locked_s && (stable_cnt_q == STB_W'(STABLE_CYCLES - 1))) begin
            state_d = ST_RUN;
            retry_d = '0;
          end else if (timeout_cnt_q == TO_W'(LOCK_TIMEOUT - 1)) begin
            retry_d   = retry_inc;
            rst_cnt_d = '0;
            state_d   = (32'(retry_inc) >= MAX_RETRIES) ? ST_FAIL : ST_PLL_RST;
          end
        end
        ST_RUN: begin
          // Lock loss holds the system in reset but leaves the PLL running.
          if (!locked_s) begin
            state_d       = ST_WAIT_LOCK;
            timeout_cnt_d = '0;
            stable_cnt_d  = '0;
            llc_d         = (llc_q == 8'hFF) ? llc_q : llc_q + 8'd1;
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_PLL_RST;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they switch with state_q.
  always_comb begin
    pll_resetb_d  = (state_d == ST_WAIT_LOCK) || (state_d == ST_RUN);
    sys_reset_n_d = (state_d == ST_RUN);
    ready_d       = (state_d == ST_RUN);
    fail_d        = (state_d == ST_FAIL);
  end

  assign pll_resetb      = pll_resetb_q;
  assign sys_reset_n     = sys_reset_n_q;
  assign ready           = ready_q;
  assign fail            = fail_q;
  assign retry_count     = retry_q;
  assign lock_loss_count = llc_q;

endmodule
